// File: rtl/half_adder_pkg.sv
// ============================================================================
// half_adder_pkg : shared constants and result type for the half-adder family
// Revision 1.0
// ============================================================================
`default_nettype none

package half_adder_pkg;

  localparam int LANES_DEF = 1;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;

endpackage : half_adder_pkg

`default_nettype wire

// File: rtl/half_adder_bit.sv
// ============================================================================
// half_adder_bit : 1-bit combinational half-adder cell
// Revision 1.0
// ============================================================================
`default_nettype none

module half_adder_bit
  import half_adder_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  ha_result_t w_res;

  assign w_res.sum   = i_a ^ i_b;
  assign w_res.carry = i_a & i_b;

  assign o_sum   = w_res.sum;
  assign o_carry = w_res.carry;

endmodule : half_adder_bit

`default_nettype wire

// File: rtl/half_adder_unit.sv
// ============================================================================
// half_adder_unit : LANES-wide half adder with registered copy and
//                   saturating carry-event counter
// Revision 1.0
// ============================================================================
`default_nettype none

module half_adder_unit
  import half_adder_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic             out_valid,
  output logic [LANES-1:0] sum_q,
  output logic [LANES-1:0] carry_q,
  output logic [CNT_W-1:0] carry_events
);

  // Accumulator is wide enough for both the counter and a full-lane popcount,
  // plus one headroom bit so overflow is detectable before clamping.
  localparam int c_PC_W   = $clog2(LANES + 1);
  localparam int c_BASE_W = (CNT_W > c_PC_W) ? CNT_W : c_PC_W;
  localparam int c_SUM_W  = c_BASE_W + 1;
  localparam logic [c_SUM_W-1:0] c_MAX = c_SUM_W'({CNT_W{1'b1}});

  logic [LANES-1:0]   w_sum;
  logic [LANES-1:0]   w_carry;
  logic [c_SUM_W-1:0] w_pop;
  logic [c_SUM_W-1:0] w_next;
  logic [c_SUM_W-1:0] w_sat;

  logic               r_out_valid;
  logic [LANES-1:0]   r_sum_q;
  logic [LANES-1:0]   r_carry_q;
  logic [CNT_W-1:0]   r_cnt;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    half_adder_bit u_bit (
      .i_a     (a[gi]),
      .i_b     (b[gi]),
      .o_sum   (w_sum[gi]),
      .o_carry (w_carry[gi])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + c_SUM_W'(w_carry[i]);
    end
    w_next = c_SUM_W'(r_cnt) + w_pop;
    w_sat  = (w_next > c_MAX) ? c_MAX : w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum_q     <= '0;
      r_carry_q   <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q   <= w_sum;
        r_carry_q <= w_carry;
        r_cnt     <= w_sat[CNT_W-1:0];
      end
    end
  end

  assign sum          = w_sum;
  assign carry        = w_carry;
  assign out_valid    = r_out_valid;
  assign sum_q        = r_sum_q;
  assign carry_q      = r_carry_q;
  assign carry_events = r_cnt;

endmodule : half_adder_unit

`default_nettype wire

// File: tb/tb_half_adder_unit.sv
// ============================================================================
// tb_half_adder_unit : directed bench for half_adder_unit in three configs
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_half_adder_unit;

  logic clk;
  logic rst_n;

  // LANES=1, CNT_W=16
  logic        v1, a1, b1;
  logic        s1, c1, ov1, sq1, cq1;
  logic [15:0] ev1;

  // LANES=4, CNT_W=16
  logic        v4;
  logic [3:0]  a4, b4, s4, c4, sq4, cq4;
  logic        ov4;
  logic [15:0] ev4;

  // LANES=2, CNT_W=2
  logic        v2;
  logic [1:0]  a2, b2, s2, c2, sq2, cq2;
  logic        ov2;
  logic [1:0]  ev2;

  int n_checks;
  int n_fail;

  half_adder_unit #(.LANES(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .sum(s1), .carry(c1), .out_valid(ov1), .sum_q(sq1), .carry_q(cq1),
    .carry_events(ev1)
  );

  half_adder_unit #(.LANES(4), .CNT_W(16)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
    .sum(s4), .carry(c4), .out_valid(ov4), .sum_q(sq4), .carry_q(cq4),
    .carry_events(ev4)
  );

  half_adder_unit #(.LANES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2),
    .sum(s2), .carry(c2), .out_valid(ov2), .sum_q(sq2), .carry_q(cq2),
    .carry_events(ev2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [1:0] sweep_ab  [4];
  logic [1:0] sweep_exp [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0;
    v4 = 0; a4 = 0; b4 = 0;
    v2 = 0; a2 = 0; b2 = 0;

    sweep_ab[0] = 2'b00; sweep_exp[0] = 2'b00;
    sweep_ab[1] = 2'b01; sweep_exp[1] = 2'b10;
    sweep_ab[2] = 2'b10; sweep_exp[2] = 2'b10;
    sweep_ab[3] = 2'b11; sweep_exp[3] = 2'b01;

    // Reset state
    #1;
    check("rst_ov1", ov1, 0);
    check("rst_sq1", sq1, 0);
    check("rst_cq1", cq1, 0);
    check("rst_ev1", ev1, 0);
    check("rst_ov4", ov4, 0);
    check("rst_ev4", ev4, 0);
    check("rst_ev2", ev2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-lane combinational sweep, {sum,carry}
    for (int i = 0; i < 4; i++) begin
      a1 = sweep_ab[i][1];
      b1 = sweep_ab[i][0];
      #5;
      check($sformatf("sweep%0d", i), {30'd0, s1, c1}, {30'd0, sweep_exp[i]});
    end

    // Registered latency
    @(negedge clk);
    v1 = 1; a1 = 1; b1 = 1;
    @(posedge clk); #1;
    check("lat_sq1", sq1, 0);
    check("lat_cq1", cq1, 1);
    check("lat_ov1", ov1, 1);
    check("lat_ev1", ev1, 1);
    v1 = 0; a1 = 0; b1 = 1;
    @(posedge clk); #1;
    check("hold_ov1", ov1, 0);
    check("hold_sq1", sq1, 0);
    check("hold_cq1", cq1, 1);
    check("hold_ev1", ev1, 1);

    // Multi-lane
    @(negedge clk);
    v4 = 1; a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check("ml_sum", s4, 4'b0110);
    check("ml_carry", c4, 4'b1000);
    @(posedge clk); #1;
    check("ml_sq", sq4, 4'b0110);
    check("ml_cq", cq4, 4'b1000);
    check("ml_ev", ev4, 1);
    v4 = 0;
    @(posedge clk); #1;
    check("ml_ev_hold", ev4, 1);
    check("ml_ov_low", ov4, 0);

    // Saturation 0 -> 2 -> 3 -> 3
    @(negedge clk);
    v2 = 1; a2 = 2'b11; b2 = 2'b11;
    #1;
    check("sat0", ev2, 0);
    @(posedge clk); #1;
    check("sat1", ev2, 2);
    @(posedge clk); #1;
    check("sat2", ev2, 3);
    @(posedge clk); #1;
    check("sat3", ev2, 3);
    v2 = 0;

    // Bring u_l4 to 5 events with out_valid high, then reset between edges
    @(negedge clk);
    v4 = 1; a4 = 4'b1111; b4 = 4'b1111;
    @(posedge clk); #1;
    check("pre_ev4", ev4, 5);
    check("pre_ov4", ov4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ov4", ov4, 0);
    check("mid_sq4", sq4, 0);
    check("mid_cq4", cq4, 0);
    check("mid_ev4", ev4, 0);
    check("mid_sum4", s4, 4'b0000);
    check("mid_carry4", c4, 4'b1111);
    @(negedge clk);
    v4 = 0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_half_adder_unit

`default_nettype wire
